// File: rtl/md_seq_ctrl_if.sv
// HI/LO sequencer bundle: EX-side op request, multiplier/divider handshakes and
// the HI/LO register-file write port.
//   slave  : the sequencer (md_seq_ctrl)
//   master : the surroundings (EX stage, multiplier, divider, HI/LO file)
interface md_seq_ctrl_if;
    logic        flush;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        stallreq;
    logic        busy;
    logic        mul_start;
    logic        mul_signed;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_result;
    logic        div_start;
    logic        div_annul;
    logic        div_signed;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_ready;
    logic [63:0] div_result;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;

    modport slave (
        input  flush, op_valid, op_code, src1, src2,
        input  mul_result, div_ready, div_result,
        output stallreq, busy,
        output mul_start, mul_signed, mul_a, mul_b,
        output div_start, div_annul, div_signed, div_a, div_b,
        output hi_we, lo_we, hi_wdata, lo_wdata
    );

    modport master (
        output flush, op_valid, op_code, src1, src2,
        output mul_result, div_ready, div_result,
        input  stallreq, busy,
        input  mul_start, mul_signed, mul_a, mul_b,
        input  div_start, div_annul, div_signed, div_a, div_b,
        input  hi_we, lo_we, hi_wdata, lo_wdata
    );
endinterface

// File: rtl/md_seq_ctrl.sv
// md_seq_ctrl: sequences the HI/LO arithmetic units behind EX.
// Accepts one mult/multu/div/divu/mthi/mtlo op, launches the pipelined
// multiplier or iterative divider, stalls the pipeline until the result is
// available and then issues a single-cycle HI/LO write.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   bus (slave)     op request (flush/op_valid/op_code/src1/src2), stallreq/busy,
//                   multiplier and divider handshakes, HI/LO write port
// Parameters:
//   MUL_LAT  multiplier latency after mul_start (1..7)
//   DIV_TMO  divider watchdog in DIV_RUN cycles
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no op in flight; mthi/mtlo written straight through
// MUL_WAIT | multiplier running, counting down to result
// DIV_RUN  | divider running (div_start held), watchdog counting
// DONE     | one cycle HI/LO write of the captured result
module md_seq_ctrl #(
    parameter int MUL_LAT = 2,
    parameter int DIV_TMO = 40
) (
    input logic          clk,
    input logic          rst,
    md_seq_ctrl_if.slave bus
);
    localparam int              WD_W     = $clog2(DIV_TMO + 1);
    localparam logic [2:0]      CNT_INIT = 3'(MUL_LAT - 1);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(DIV_TMO - 1);

    typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_RUN, DONE} state_t;

    state_t          state;
    logic [2:0]      cnt;
    logic [WD_W-1:0] wd;
    logic [31:0]     a_q;
    logic [31:0]     b_q;
    logic            sgn_q;
    logic [63:0]     res_q;
    logic [1:0]      mask_q;

    logic in_idle, op_mul, op_div, op_mthi, op_mtlo, wd_expire;

    assign in_idle   = (state == IDLE);
    assign op_mul    = bus.op_valid && (bus.op_code[2:1] == 2'b00);
    assign op_div    = bus.op_valid && (bus.op_code[2:1] == 2'b01);
    assign op_mthi   = bus.op_valid && (bus.op_code == 3'd4);
    assign op_mtlo   = bus.op_valid && (bus.op_code == 3'd5);
    // A ready response in the final watchdog cycle still wins over the timeout.
    assign wd_expire = (state == DIV_RUN) && !bus.div_ready && (wd == WD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            wd     <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sgn_q  <= 1'b0;
            res_q  <= '0;
            mask_q <= 2'b00;
        end else if (bus.flush) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (op_mul || op_div) begin
                        a_q   <= bus.src1;
                        b_q   <= bus.src2;
                        sgn_q <= ~bus.op_code[0];
                    end
                    if (op_mul) begin
                        cnt   <= CNT_INIT;
                        state <= MUL_WAIT;
                    end else if (op_div) begin
                        if (bus.src2 == 32'd0) begin
                            // Divide-by-zero never reaches the divider.
                            res_q  <= {bus.src1, 32'hFFFF_FFFF};
                            mask_q <= 2'b11;
                            state  <= DONE;
                        end else begin
                            wd    <= '0;
                            state <= DIV_RUN;
                        end
                    end
                end
                MUL_WAIT: begin
                    if (cnt == 3'd0) begin
                        res_q  <= bus.mul_result;
                        mask_q <= 2'b11;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                DIV_RUN: begin
                    wd <= wd + 1'b1;
                    if (bus.div_ready) begin
                        res_q  <= bus.div_result;
                        mask_q <= 2'b11;
                        state  <= DONE;
                    end else if (wd == WD_LAST) begin
                        res_q  <= '0;
                        mask_q <= 2'b11;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    // op_valid is still the op just finished; do not relaunch it.
                    mask_q <= 2'b00;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = !in_idle;
    assign bus.stallreq  = !bus.flush &&
                           ((in_idle && (op_mul || op_div)) ||
                            (state == MUL_WAIT) || (state == DIV_RUN));

    // Operands are forwarded on the launch cycle so the multiplier sees them
    // together with mul_start; afterwards the latched copies hold them.
    assign bus.mul_start  = in_idle && op_mul && !bus.flush;
    assign bus.mul_a      = bus.mul_start ? bus.src1 : a_q;
    assign bus.mul_b      = bus.mul_start ? bus.src2 : b_q;
    assign bus.mul_signed = bus.mul_start ? ~bus.op_code[0] : sgn_q;

    assign bus.div_start  = (state == DIV_RUN);
    assign bus.div_annul  = ((state == DIV_RUN) && bus.flush) || wd_expire;
    assign bus.div_signed = sgn_q;
    assign bus.div_a      = a_q;
    assign bus.div_b      = b_q;

    assign bus.hi_we    = !bus.flush && (((state == DONE) && mask_q[1]) || (in_idle && op_mthi));
    assign bus.lo_we    = !bus.flush && (((state == DONE) && mask_q[0]) || (in_idle && op_mtlo));
    assign bus.hi_wdata = (state == DONE)      ? res_q[63:32] :
                          (in_idle && op_mthi) ? bus.src1     : 32'd0;
    assign bus.lo_wdata = (state == DONE)      ? res_q[31:0]  :
                          (in_idle && op_mtlo) ? bus.src1     : 32'd0;
endmodule

// File: tb/tb_md_seq_ctrl.sv
module tb_md_seq_ctrl;
    localparam int MUL_LAT = 2;
    localparam int DIV_TMO = 40;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    md_seq_ctrl_if bus();

    md_seq_ctrl #(.MUL_LAT(MUL_LAT), .DIV_TMO(DIV_TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.flush      = 1'b0;
        bus.op_valid   = 1'b0;
        bus.op_code    = 3'd0;
        bus.src1       = 32'd0;
        bus.src2       = 32'd0;
        bus.mul_result = 64'd0;
        bus.div_ready  = 1'b0;
        bus.div_result = 64'd0;
    endtask

    // Arithmetic meaning of each op: {HI, LO}.
    function automatic logic [63:0] ref_result(input int op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            0: return 64'(sa * sb);
            1: return ua * ub;
            2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {32'((ua % ub)), 32'((ua / ub))};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Runs one op with the EX operands held until the write, then one idle cycle.
    // rdy_at: cycle index (from the launch cycle 0) at which div_ready is given; 0 = never.
    task automatic run_op(input string name, input int op, input logic [31:0] a,
                          input logic [31:0] b, input int rdy_at);
        int          stall_n, wr_at, mstart_n, dstart_n, annul_n, limit;
        int          exp_stall, exp_wr, exp_dstart, exp_annul, exp_mstart;
        logic [1:0]  wr_mask, exp_mask;
        logic [31:0] hi_d, lo_d;
        logic [63:0] resp, exp_data;
        bit          is_mul, is_div, dz;
        stall_n = 0; wr_at = -1; mstart_n = 0; dstart_n = 0; annul_n = 0;
        wr_mask = 2'b00; hi_d = 32'd0; lo_d = 32'd0;
        resp     = ref_result(op, a, b);
        exp_data = resp;
        is_mul   = (op == 0 || op == 1);
        is_div   = (op == 2 || op == 3);
        dz       = is_div && (b == 32'd0);
        exp_dstart = 0; exp_annul = 0; exp_mstart = is_mul ? 1 : 0;
        if (is_mul) begin
            exp_stall = MUL_LAT + 1; exp_wr = MUL_LAT + 1; exp_mask = 2'b11;
        end else if (dz) begin
            exp_stall = 1; exp_wr = 1; exp_mask = 2'b11;
        end else if (is_div && rdy_at != 0) begin
            exp_stall = rdy_at + 1; exp_wr = rdy_at + 1; exp_mask = 2'b11; exp_dstart = rdy_at;
        end else if (is_div) begin
            exp_stall = DIV_TMO + 1; exp_wr = DIV_TMO + 1; exp_mask = 2'b11;
            exp_dstart = DIV_TMO; exp_annul = 1; exp_data = 64'd0;
        end else if (op == 4) begin
            exp_stall = 0; exp_wr = 0; exp_mask = 2'b10; exp_data = {a, 32'd0};
        end else if (op == 5) begin
            exp_stall = 0; exp_wr = 0; exp_mask = 2'b01; exp_data = {32'd0, a};
        end else begin
            exp_stall = 0; exp_wr = -1; exp_mask = 2'b00;
        end
        limit = (op > 5) ? 4 : DIV_TMO + 8;

        for (int i = 0; i < limit; i++) begin
            bus.op_valid   = 1'b1;
            bus.op_code    = 3'(op);
            bus.src1       = a;
            bus.src2       = b;
            bus.mul_result = (is_mul && i == MUL_LAT) ? resp : {$urandom, $urandom};
            bus.div_ready  = is_div && (rdy_at != 0) && (i == rdy_at);
            bus.div_result = bus.div_ready ? resp : {$urandom, $urandom};
            @(negedge clk);
            if (bus.stallreq)  stall_n++;
            if (bus.mul_start) mstart_n++;
            if (bus.div_start) dstart_n++;
            if (bus.div_annul) annul_n++;
            if (i == 0 && is_mul) begin
                checks++;
                if ({bus.mul_a, bus.mul_b, bus.mul_signed} !== {a, b, (op == 0)}) begin
                    errors++;
                    $display("FAIL %s mul_operands: got a=%h b=%h s=%b expected a=%h b=%h s=%b",
                             name, bus.mul_a, bus.mul_b, bus.mul_signed, a, b, (op == 0));
                end
            end
            if (i == 1 && is_div && !dz) begin
                checks++;
                if ({bus.div_a, bus.div_b, bus.div_signed} !== {a, b, (op == 2)}) begin
                    errors++;
                    $display("FAIL %s div_operands: got a=%h b=%h s=%b expected a=%h b=%h s=%b",
                             name, bus.div_a, bus.div_b, bus.div_signed, a, b, (op == 2));
                end
            end
            if ((bus.hi_we || bus.lo_we) && wr_at < 0) begin
                wr_at   = i;
                wr_mask = {bus.hi_we, bus.lo_we};
                hi_d    = bus.hi_wdata;
                lo_d    = bus.lo_wdata;
            end
            tick();
            if (wr_at >= 0) break;
        end

        idle_inputs();
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.stallreq, bus.hi_we, bus.lo_we} !== 4'b0000) begin
            errors++;
            $display("FAIL %s after_write_idle: got busy/stall/hwe/lwe=%b expected 0000",
                     name, {bus.busy, bus.stallreq, bus.hi_we, bus.lo_we});
        end
        tick();

        checks++;
        if (stall_n !== exp_stall) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d expected %0d", name, stall_n, exp_stall);
        end
        checks++;
        if (wr_at !== exp_wr || wr_mask !== exp_mask) begin
            errors++;
            $display("FAIL %s write_timing: got cycle %0d mask %b expected cycle %0d mask %b",
                     name, wr_at, wr_mask, exp_wr, exp_mask);
        end
        if (exp_mask[1]) begin
            checks++;
            if (hi_d !== exp_data[63:32]) begin
                errors++;
                $display("FAIL %s hi_wdata: got %h expected %h", name, hi_d, exp_data[63:32]);
            end
        end
        if (exp_mask[0]) begin
            checks++;
            if (lo_d !== exp_data[31:0]) begin
                errors++;
                $display("FAIL %s lo_wdata: got %h expected %h", name, lo_d, exp_data[31:0]);
            end
        end
        checks++;
        if (mstart_n !== exp_mstart || dstart_n !== exp_dstart || annul_n !== exp_annul) begin
            errors++;
            $display("FAIL %s unit_handshake: got mul_start=%0d div_start=%0d annul=%0d expected %0d %0d %0d",
                     name, mstart_n, dstart_n, annul_n, exp_mstart, exp_dstart, exp_annul);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if ({bus.stallreq, bus.busy, bus.mul_start, bus.div_start, bus.div_annul,
             bus.hi_we, bus.lo_we} !== 7'd0) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 0000000",
                     {bus.stallreq, bus.busy, bus.mul_start, bus.div_start, bus.div_annul, bus.hi_we, bus.lo_we});
        end
        checks++;
        if ({bus.mul_a, bus.mul_b, bus.div_a, bus.div_b, bus.hi_wdata, bus.lo_wdata} !== 192'd0) begin
            errors++;
            $display("FAIL reset_data: got mul_a=%h div_b=%h hi=%h lo=%h expected all 0",
                     bus.mul_a, bus.div_b, bus.hi_wdata, bus.lo_wdata);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        run_op("T1_mult", 0, 32'hFFFF_FFFD, 32'd7, 0);
        run_op("T2_divu", 3, 32'd100, 32'd7, 33);
        run_op("T3_divzero", 2, 32'hCAFE_0001, 32'd0, 0);
        run_op("T6_watchdog", 2, 32'd12345, 32'd11, 0);
        run_op("multu_max", 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("div_ready_last", 2, 32'hFFFF_FF9C, 32'd7, DIV_TMO - 1);
        run_op("op6_ignored", 6, 32'h1, 32'h2, 0);
    endtask

    task automatic test_back_to_back();
        int stall_n;
        stall_n = 0;
        bus.op_valid = 1'b1; bus.op_code = 3'd4; bus.src1 = 32'h1234;
        @(negedge clk);
        if (bus.stallreq) stall_n++;
        checks++;
        if ({bus.hi_we, bus.lo_we, bus.hi_wdata} !== {2'b10, 32'h1234}) begin
            errors++;
            $display("FAIL b2b_mthi: got we=%b data=%h expected we=10 data=00001234",
                     {bus.hi_we, bus.lo_we}, bus.hi_wdata);
        end
        tick();
        bus.op_code = 3'd5; bus.src1 = 32'h5678;
        @(negedge clk);
        if (bus.stallreq) stall_n++;
        checks++;
        if ({bus.hi_we, bus.lo_we, bus.lo_wdata} !== {2'b01, 32'h5678}) begin
            errors++;
            $display("FAIL b2b_mtlo: got we=%b data=%h expected we=01 data=00005678",
                     {bus.hi_we, bus.lo_we}, bus.lo_wdata);
        end
        tick();
        idle_inputs();
        checks++;
        if (stall_n !== 0) begin
            errors++;
            $display("FAIL b2b_stall: got %0d stall cycles expected 0", stall_n);
        end
    endtask

    task automatic test_flush_div();
        int writes;
        logic annul_seen, stall_seen;
        writes = 0;
        for (int i = 0; i < 10; i++) begin
            bus.op_valid = 1'b1; bus.op_code = 3'd3; bus.src1 = 32'd1000; bus.src2 = 32'd3;
            @(negedge clk);
            if (bus.hi_we || bus.lo_we) writes++;
            tick();
        end
        bus.flush = 1'b1;
        @(negedge clk);
        annul_seen = bus.div_annul;
        stall_seen = bus.stallreq;
        if (bus.hi_we || bus.lo_we) writes++;
        tick();
        idle_inputs();
        checks++;
        if ({annul_seen, stall_seen} !== 2'b10) begin
            errors++;
            $display("FAIL flush_annul: got annul/stall=%b expected 10", {annul_seen, stall_seen});
        end
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.div_start, bus.div_annul} !== 3'b000) begin
            errors++;
            $display("FAIL flush_idle: got busy/dstart/annul=%b expected 000",
                     {bus.busy, bus.div_start, bus.div_annul});
        end
        for (int i = 0; i < 6; i++) begin
            bus.div_ready = (i == 1);
            bus.div_result = 64'h1;
            @(negedge clk);
            if (bus.hi_we || bus.lo_we) writes++;
            tick();
        end
        idle_inputs();
        checks++;
        if (writes !== 0) begin
            errors++;
            $display("FAIL flush_no_write: got %0d writes expected 0", writes);
        end
    endtask

    task automatic test_reset_mid_mul();
        int writes;
        writes = 0;
        bus.op_valid = 1'b1; bus.op_code = 3'd0; bus.src1 = 32'h55; bus.src2 = 32'h66;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.stallreq, bus.mul_start, bus.hi_we, bus.lo_we, bus.mul_a, bus.mul_b, bus.mul_signed}
            !== 70'd0) begin
            errors++;
            $display("FAIL rst_mid_mul: got busy=%b stall=%b mul_a=%h mul_b=%h expected all 0",
                     bus.busy, bus.stallreq, bus.mul_a, bus.mul_b);
        end
        for (int i = 0; i < 5; i++) begin
            bus.mul_result = 64'hDEAD;
            @(negedge clk);
            if (bus.hi_we || bus.lo_we) writes++;
            tick();
        end
        idle_inputs();
        checks++;
        if (writes !== 0) begin
            errors++;
            $display("FAIL rst_mid_mul_no_write: got %0d writes expected 0", writes);
        end
    endtask

    task automatic test_random();
        int op, rdy;
        logic [31:0] a, b;
        for (int n = 0; n < 40; n++) begin
            op  = int'($urandom_range(0, 7));
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            rdy = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, DIV_TMO - 1));
            run_op($sformatf("rand%0d_op%0d", n, op), op, a, b, rdy);
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush_div();
        test_reset_mid_mul();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
